// File: rtl/vec_rd_streamer_pkg.sv
// Types and helpers for vec_rd_streamer: FSM encoding and RAM word address generation.
`include "constants.vh"

package vec_rd_streamer_pkg;

  typedef enum logic [1:0] {
    VRS_ST_IDLE  = `VRS_IDLE,
    VRS_ST_RUN   = `VRS_RUN,
    VRS_ST_DRAIN = `VRS_DRAIN
  } vrs_state_e;

  localparam int ADDR_W     = `BE_ADDR_W;
  localparam int DATA_W     = `BE_DATA_W;
  localparam int RAM_SPAN_W = `VRS_RAM_SPAN_W;
  localparam int K_LO_W     = RAM_SPAN_W - 3;

  // Address of word k: low bits wrap inside the RAM span, upper bits follow base.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [K_LO_W-1:0] k);
    logic [RAM_SPAN_W-1:0] low;
    low = base[RAM_SPAN_W-1:0] + {k, 3'b000};
    return {base[ADDR_W-1:RAM_SPAN_W], low};
  endfunction

endpackage

// File: rtl/constants.vh
// Shared widths for the vector-RAM back end plus vec_rd_streamer state codes.
`ifndef CONSTANTS_VH
`define CONSTANTS_VH

`define BE_ADDR_W      24
`define BE_DATA_W      64
`define BE_STRB_W      8

`define VRS_IDLE       2'd0
`define VRS_RUN        2'd1
`define VRS_DRAIN      2'd2
`define VRS_RAM_SPAN_W 15

`endif

// File: rtl/vec_rd_fifo.sv
// Synchronous FIFO holding returned RAM words plus their last flag; output reads 0 when empty.
module vec_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign do_push = push_i && (count_q != (PW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = empty_o ? '0 : mem[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/vec_rd_streamer.sv
// Sequential 8-byte reader from the vector RAM feeding a valid/ready stream with last flag.
// Optional stall counter output when VEC_RD_STALL_CNT_EN is defined.
`include "constants.vh"

module vec_rd_streamer
  import vec_rd_streamer_pkg::*;
#(
  parameter int LEN_W      = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [`BE_ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]      len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ram_en_o,
  output logic [`BE_STRB_W-1:0] ram_we_o,
  output logic [`BE_ADDR_W-1:0] ram_addr_o,
  input  logic [`BE_DATA_W-1:0] ram_d_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [`BE_DATA_W-1:0] m_data_o,
  output logic                  m_last_o,
`ifdef VEC_RD_STALL_CNT_EN
  output logic [31:0]           stall_cnt_o,
`endif
  output logic [1:0]            dbg_state_o
);
  // Stream handshake: a word moves when m_valid_o & m_ready_i at a rising edge;
  // m_valid_o never depends on m_ready_i and data/last hold while stalled.
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  vrs_state_e            state_q, state_d;
  logic [ADDR_W-1:0]     base_q;
  logic [LEN_W-1:0]      len_q, k_q;
  logic [K_LO_W-1:0]     k_lo;
  logic                  inflight_q, inflight_last_q, zero_done_q;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic [DATA_W:0]       fifo_dout;
  logic                  start_ok, issue, issue_last, drain_done, pop;

  assign start_ok   = start_i && (state_q == VRS_ST_IDLE);
  assign issue      = (state_q == VRS_ST_RUN) &&
                      (({1'b0, fifo_count} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(FIFO_DEPTH));
  assign issue_last = (k_q == len_q - LEN_W'(1));
  assign drain_done = (state_q == VRS_ST_DRAIN) && fifo_empty && !inflight_q;
  assign pop        = m_valid_o && m_ready_i;
  assign k_lo       = K_LO_W'(k_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      VRS_ST_IDLE:  if (start_i && (len_i != '0)) state_d = VRS_ST_RUN;
      VRS_ST_RUN:   if (issue && issue_last) state_d = VRS_ST_DRAIN;
      VRS_ST_DRAIN: if (drain_done) state_d = VRS_ST_IDLE;
      default:      state_d = VRS_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= VRS_ST_IDLE;
      base_q          <= '0;
      len_q           <= '0;
      k_q             <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      zero_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      zero_done_q     <= start_ok && (len_i == '0);
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_last;
      if (start_ok) begin
        base_q <= base_addr_i;
        len_q  <= len_i;
        k_q    <= '0;
      end else if (issue) begin
        k_q <= k_q + LEN_W'(1);
      end
    end
  end

  // The read returns the cycle after issue and is pushed exactly once, tagged with its last flag.
  vec_rd_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W + 1)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .din_i   ({inflight_last_q, ram_d_i}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign ram_en_o    = issue;
  assign ram_addr_o  = issue ? word_addr(base_q, k_lo) : '0;
  assign ram_we_o    = '0;
  assign m_valid_o   = !fifo_empty;
  assign m_data_o    = fifo_dout[DATA_W-1:0];
  assign m_last_o    = fifo_dout[DATA_W];
  assign busy_o      = (state_q != VRS_ST_IDLE);
  assign done_o      = drain_done || zero_done_q;
  assign dbg_state_o = state_q;

`ifdef VEC_RD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || start_ok) begin
      stall_cnt_q <= '0;
    end else if (busy_o && m_valid_o && !m_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif
endmodule
